// File: rtl/booth_mul_8bit_pkg.sv
// Shared types for the radix-2 Booth multiplier.
// FSM states, Booth op decode and default width.
package booth_mul_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NOP,
    ADD,
    SUB
  } op_t;

  function automatic op_t booth_decode(
    input logic q0,
    input logic q1
  );
    op_t op;
    unique case (1'b1)
      (!q0 && q1): op = ADD;
      (q0 && !q1): op = SUB;
      default:     op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mul_8bit_if.sv
// Operand/product handshake bundle for booth_mul_8bit.
// master drives operands and out_ready; slave is the multiplier.
interface booth_mul_8bit_if #(
  parameter int W = booth_mul_pkg::W_DEF
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  modport master (
    output in_valid,
    output x,
    output y,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  p,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  x,
    input  y,
    input  out_ready,
    output in_ready,
    output out_valid,
    output p,
    output busy
  );

endinterface

// File: rtl/booth_mul_8bit_step.sv
// One Booth iteration: (W+1)-bit ripple add/sub of sext(M)
// followed by an arithmetic right shift of {A,Q,q_1}.
module booth_step
  import booth_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic         q_1,
  input  logic [W-1:0] m,
  output logic [W:0]   a_n,
  output logic [W-1:0] q_n,
  output logic         q_1_n
);

  op_t        op;
  logic [W:0] ms;
  logic [W:0] opnd;
  logic       sub;
  logic [W:0] sum;

  assign ms = {m[W-1], m};

  always_comb begin
    op   = booth_decode(q[0], q_1);
    sub  = 1'b0;
    opnd = '0;
    unique case (op)
      ADD: begin
        opnd = ms;
      end
      SUB: begin
        opnd = ~ms;
        sub  = 1'b1;
      end
      default: begin
        opnd = '0;
      end
    endcase
    // carry out of the top bit is dropped
    sum = a + opnd + {{W{1'b0}}, sub};
  end

  assign {a_n, q_n, q_1_n} = {sum[W], sum, q};

endmodule

// File: rtl/booth_mul_8bit.sv
// Sequential radix-2 Booth signed multiplier, W steps per product.
// BOOTH_ZERO_SKIP_EN: zero operands bypass RUN and return p=0.
module booth_mul_8bit
  import booth_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input logic             clk,
  input logic             rst,
  booth_mul_8bit_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  state_t         state;
  logic [W:0]     a;
  logic [W-1:0]   q;
  logic           q_1;
  logic [W-1:0]   m;
  logic [CW-1:0]  cnt;
  logic           out_valid;
  logic [2*W-1:0] p;

  logic [W:0]     a_n;
  logic [W-1:0]   q_n;
  logic           q_1_n;

  booth_step #(.W(W)) u_step (
    .a     (a),
    .q     (q),
    .q_1   (q_1),
    .m     (m),
    .a_n   (a_n),
    .q_n   (q_n),
    .q_1_n (q_1_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      m         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m     <= bus.x;
            q     <= bus.y;
            a     <= '0;
            q_1   <= 1'b0;
            cnt   <= CW'(W);
            state <= RUN;
`ifdef BOOTH_ZERO_SKIP_EN
            if (bus.x == '0 || bus.y == '0) begin
              p     <= '0;
              cnt   <= '0;
              state <= DONE;
            end
`endif
          end
        end
        RUN: begin
          if (cnt != '0) begin
            a   <= a_n;
            q   <= q_n;
            q_1 <= q_1_n;
            cnt <= cnt - CW'(1);
          end else begin
            p         <= {a[W-1:0], q};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // zero-skip arrives with out_valid still low
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = out_valid;
  assign bus.p         = p;

endmodule
